// File: rtl/dmem_store_buffer_if.sv
// Core and SRAM signal bundle for the data-memory store buffer.
// slave = buffer view, master = core/SRAM environment view.
interface dmem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] coreAddress;
  logic [DW-1:0] coreWriteData;
  logic          coreWriteEnable;
  logic          coreReadEnable;
  logic [DW-1:0] coreReadData;
  logic          coreStall;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWriteData;
  logic          memWriteEnable;
  logic [DW-1:0] memReadData;
  logic          memReady;
  logic          bufEmpty;

  modport slave (
    input  coreAddress, coreWriteData, coreWriteEnable, coreReadEnable,
    input  memReadData, memReady,
    output coreReadData, coreStall, memAddress, memWriteData, memWriteEnable,
    output bufEmpty
  );

  modport master (
    output coreAddress, coreWriteData, coreWriteEnable, coreReadEnable,
    output memReadData, memReady,
    input  coreReadData, coreStall, memAddress, memWriteData, memWriteEnable,
    input  bufEmpty
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write FIFO between the core data port and the data SRAM, with load forwarding.
// Optional in-place store coalescing: define DMEM_STORE_COALESCE_EN.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  dmem_store_buffer_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0] dbgCount
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WAW = AW - 2;

  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count;
  logic [DEPTH-1:0] validQ;
  logic [WAW-1:0] addrQ [DEPTH];
  logic [DW-1:0]  dataQ [DEPTH];

  logic [WAW-1:0] wordAddr;
  logic           hitAny;
  logic [DW-1:0]  fwdData;
  logic [PW-1:0]  scanIdx;
`ifdef DMEM_STORE_COALESCE_EN
  logic [PW-1:0]  matchIdx;
`endif
  logic full, notEmpty, readMiss, serveLoad, drainHead, pop;
  logic coalesceHit, storeAccept, alloc;

  assign wordAddr = bus.coreAddress[AW-1:2];
  assign dbgCount = count;

  // Scan oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    hitAny  = 1'b0;
    fwdData = '0;
    scanIdx = '0;
`ifdef DMEM_STORE_COALESCE_EN
    matchIdx = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = head + PW'(i);
      if (validQ[scanIdx] && addrQ[scanIdx] == wordAddr) begin
        hitAny  = 1'b1;
        fwdData = dataQ[scanIdx];
`ifdef DMEM_STORE_COALESCE_EN
        matchIdx = scanIdx;
`endif
      end
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign notEmpty  = (count != '0);
  assign readMiss  = bus.coreReadEnable && !hitAny;
  assign serveLoad = readMiss && !full;
  assign drainHead = !serveLoad && notEmpty && !reset;
  assign pop       = drainHead && bus.memReady;

`ifdef DMEM_STORE_COALESCE_EN
  // A head that is leaving this cycle cannot absorb the store; it allocates instead.
  assign coalesceHit = bus.coreWriteEnable && hitAny && !(matchIdx == head && pop);
`else
  assign coalesceHit = 1'b0;
`endif

  always_comb begin
    bus.memAddress     = bus.coreAddress;
    bus.memWriteData   = '0;
    bus.memWriteEnable = 1'b0;
    bus.coreReadData   = bus.memReadData;
    bus.coreStall      = 1'b0;
    if (reset) begin
      bus.memAddress = '0;
    end else begin
      if (drainHead) begin
        bus.memAddress     = {addrQ[head], 2'b00};
        bus.memWriteData   = dataQ[head];
        bus.memWriteEnable = 1'b1;
      end
      if (bus.coreReadEnable) begin
        if (hitAny)         bus.coreReadData = fwdData;
        else if (serveLoad) bus.coreStall    = !bus.memReady;
        else                bus.coreStall    = 1'b1;
      end else if (bus.coreWriteEnable) begin
        bus.coreStall = full && !pop && !coalesceHit;
      end
    end
  end

  assign bus.bufEmpty = reset || !notEmpty;
  assign storeAccept  = bus.coreWriteEnable && !bus.coreStall && !reset;
  assign alloc        = storeAccept && !coalesceHit;

  // On a full buffer the pop and the allocate hit the same slot; allocate wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      validQ <= '0;
    end else begin
      if (pop) begin
        validQ[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (alloc) begin
        validQ[tail] <= 1'b1;
        tail         <= tail + 1'b1;
      end
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      addrQ[tail] <= wordAddr;
      dataQ[tail] <= bus.coreWriteData;
    end
`ifdef DMEM_STORE_COALESCE_EN
    if (storeAccept && coalesceHit) dataQ[matchIdx] <= bus.coreWriteData;
`endif
  end
endmodule
